hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter NSTAGE, default 3, number of in-flight stages tracked after ID (EX, MEM, WB).
REQ-002 SHALL have parameter CNT_W, default 16, stall counter width.
REQ-003 clk  in  1  sole clock, all state on posedge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 id_valid  in  1  ID stage holds a valid instruction.
REQ-006 id_rs1_addr, id_rs2_addr  in  5 each  source register addresses.
REQ-007 id_uses_rs1, id_uses_rs2  in  1 each  instruction reads that source.
REQ-008 id_rd_addr  in  5  destination address.
REQ-009 id_writes_rd  in  1  instruction writes rd.
REQ-010 flush  in  1  branch/jump redirect from EX; kill IF and ID this cycle.
REQ-011 stall_if_id  out  1  hold PC and IF/ID register.
REQ-012 bubble_id_ex  out  1  load NOP into ID/EX: all ALU enables 0, rd write 0.
REQ-013 stall_cnt  out  CNT_W  saturating count of stall cycles.
REQ-014 busy  out  1  any tracked stage holds a pending rd write.

Function
REQ-015 SHALL keep NSTAGE slots {pend, rd}; slot 0 = EX, last = WB.
REQ-016 Each cycle slots SHALL shift: slot[i+1] <= slot[i]; the last slot's entry retires.
REQ-017 slot[0] SHALL load {1, id_rd_addr} only when id_valid & id_writes_rd & id_rd_addr != 0 & !stall_if_id & !flush; otherwise {0, 0}.
REQ-018 A source SHALL conflict when its uses bit = 1, its addr != 0, and some slot has pend = 1 with rd equal to that addr.
REQ-019 stall_if_id SHALL be combinational: id_valid & !flush & (rs1 conflict | rs2 conflict); zero-cycle latency.
REQ-020 bubble_id_ex SHALL equal stall_if_id | flush.
REQ-021 Register file writes at WB posedge and ID reads combinationally, so a WB-slot match SHALL stall; with NSTAGE = 3 a back-to-back RAW dependency stalls exactly 3 cycles.
REQ-022 x0 SHALL never create a conflict or a pending entry.
REQ-023 flush SHALL suppress the stall and insert an empty slot[0]; slots already in flight SHALL keep shifting (the EX instruction retires normally).
REQ-024 When flush and a conflict occur together, flush SHALL win: stall_if_id = 0, bubble_id_ex = 1.
REQ-025 If rs1 and rs2 both conflict with different slots, the stall SHALL persist until the youngest matching slot retires.
REQ-026 stall_cnt SHALL increment by 1 in each cycle with stall_if_id = 1 and saturate at all-ones; it never wraps.
REQ-027 busy SHALL be the OR of all pend bits.

Reset
REQ-028 On rst assertion all slots SHALL clear to {0, 0} immediately, without waiting for clk.
REQ-029 While rst is high: stall_if_id = 0, bubble_id_ex = 0, stall_cnt = 0, busy = 0.
REQ-030 On rst deassertion mid-operation, nothing SHALL survive: no pending entry and no stall are carried over.

Structure
REQ-031 riscv_pkg SHALL hold REG_ADDR_W = 5, the slot struct typedef {pend, rd}, and the NSTAGE default.
REQ-032 A sub-module hazard_match SHALL compare one source address against all slots; it is instantiated twice (rs1, rs2).
REQ-033 Output sequencing for the ID/EX pipeline register: bubble_id_ex gates its enables; stall_if_id gates PC and IF/ID.

Verification
REQ-034 add x5 then add x6,x5,x1 back-to-back -> stall_if_id high for 3 cycles, bubble_id_ex for 3 cycles, stall_cnt = 3.
REQ-035 write x0 followed by read x0 -> no stall, busy = 0.
REQ-036 Dependent instruction with flush asserted in the first stall cycle -> stall_if_id = 0, bubble_id_ex = 1, slot[0] empty, and the older x5 write still retires 2 cycles later.
REQ-037 rs1 = x3 pending in WB and rs2 = x4 pending in EX -> stall 3 cycles, released only after the x4 entry retires.
REQ-038 Force 65535 stall cycles with CNT_W = 16, then one more -> stall_cnt holds 0xFFFF.
REQ-039 Assert rst between clock edges with 2 slots pending -> busy and stall_if_id drop at once with no clk edge; after release an independent instruction issues with no stall.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared register-address width, pipeline slot type and hazard-tracking depth
package riscv_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int NSTAGE_DEF = 3;
    typedef struct packed {
        logic                  pend;
        logic [REG_ADDR_W-1:0] rd;
    } slot_t;
endpackage

// File: rtl/hazard_match.sv
// hazard_match: flags a source register that matches a pending write in any tracked slot
// Ports: uses/addr describe one ID source; slots is the in-flight table; hit is the conflict flag.
module hazard_match
    import riscv_pkg::*;
#(
    parameter int NSTAGE = NSTAGE_DEF
) (
    input  logic                  uses,
    input  logic [REG_ADDR_W-1:0] addr,
    input  slot_t [NSTAGE-1:0]    slots,
    output logic                  hit
);
    logic any;
    always_comb begin
        any = 1'b0;
        for (int i = 0; i < NSTAGE; i++)
            any = any | (slots[i].pend & (slots[i].rd == addr));
    end
    // x0 is hardwired to zero, so reading it never depends on anything in flight
    assign hit = uses & (addr != '0) & any;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: RAW hazard interlock that stalls ID while a source is still pending in EX..WB
// Ports: clk/rst (async, active-high); id_* describe the instruction in ID; flush kills IF/ID;
//        stall_if_id holds PC and IF/ID; bubble_id_ex loads a NOP into ID/EX;
//        stall_cnt saturating stall-cycle count; busy = any pending rd write in flight.
module hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int NSTAGE = NSTAGE_DEF,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd_addr,
    input  logic                  id_writes_rd,
    input  logic                  flush,
    output logic                  stall_if_id,
    output logic                  bubble_id_ex,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic                  busy
);
    slot_t [NSTAGE-1:0] slot_q, slot_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rs1_hit, rs2_hit, load;

    hazard_match #(.NSTAGE(NSTAGE)) u_rs1 (
        .uses (id_uses_rs1),
        .addr (id_rs1_addr),
        .slots(slot_q),
        .hit  (rs1_hit)
    );

    hazard_match #(.NSTAGE(NSTAGE)) u_rs2 (
        .uses (id_uses_rs2),
        .addr (id_rs2_addr),
        .slots(slot_q),
        .hit  (rs2_hit)
    );

    // WB slot is included in the match because the register file is read before the WB write lands
    assign stall_if_id  = ~rst & id_valid & ~flush & (rs1_hit | rs2_hit);
    assign bubble_id_ex = ~rst & (stall_if_id | flush);
    assign load         = id_valid & id_writes_rd & (id_rd_addr != '0) & ~stall_if_id & ~flush;
    assign stall_cnt    = cnt_q;

    always_comb begin
        slot_d = '0;
        for (int i = NSTAGE - 1; i > 0; i--)
            slot_d[i] = slot_q[i-1];
        slot_d[0].pend = load;
        slot_d[0].rd   = load ? id_rd_addr : '0;
        cnt_d = (stall_if_id && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
        busy = 1'b0;
        for (int i = 0; i < NSTAGE; i++)
            busy = busy | slot_q[i].pend;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q <= '0;
            cnt_q  <= '0;
        end else begin
            slot_q <= slot_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule
